updown_counter_param: RTL and testbench

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

---
 rtl/updown_counter_param.sv | 71 +++++++
 tb/tb_updown_counter_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Synchronous up/down counter over 0..MAX_COUNT with wrap/saturate modes,
// clear/load priority, combinational terminal count and a registered wrap pulse.
module updown_counter_param #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    assign at_max  = (q_q == MAX_V);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            // Out-of-range load values clamp so q never leaves 0..MAX_COUNT
            q_d = (d > MAX_V) ? MAX_V : d;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q_d = q_q + ONE_V;
                end else if (!sat) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_d = q_q - ONE_V;
                end else if (!sat) begin
                    q_d    = MAX_V;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign tc   = up ? at_max : at_zero;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: WIDTH=4/MAX_COUNT=9 instance driven from a vector table plus
// multi-cycle sequences, and a default-parameter instance for the 8-bit wrap.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b1, sat = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] d = '0;
    logic [7:0] d8 = '0;
    logic [3:0] q;
    logic       tc, wrap;
    logic [7:0] q8;
    logic       tc8, wrap8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .d(d), .q(q), .tc(tc), .wrap(wrap)
    );

    updown_counter_param dut8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .d(d8), .q(q8), .tc(tc8), .wrap(wrap8)
    );

    typedef struct {
        logic       clr, load, en, up, sat;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_wrap, exp_tc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic e,
                         input logic u, input logic s, input logic [3:0] dv);
        @(negedge clk);
        clr = c; load = l; en = e; up = u; sat = s; d = dv;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic e,
                                input logic u, input logic s, input logic [3:0] dv,
                                input logic [3:0] eq, input logic ew, input logic et);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up = u; v.sat = s; v.d = dv;
        v.exp_q = eq; v.exp_wrap = ew; v.exp_tc = et;
        return v;
    endfunction

    initial begin
        //             clr load en up sat  d     q  wrap tc
        vecs[0]  = mk(0, 1, 0, 1, 0, 4'd12, 4'd9, 0, 1); // clamp load
        vecs[1]  = mk(1, 1, 0, 1, 0, 4'd3,  4'd0, 0, 0); // clr beats load
        vecs[2]  = mk(0, 1, 0, 1, 0, 4'd5,  4'd5, 0, 0); // load with en=0
        vecs[3]  = mk(0, 0, 1, 1, 0, 4'd0,  4'd6, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 4'd0,  4'd5, 0, 0); // direction change
        vecs[5]  = mk(0, 1, 0, 0, 0, 4'd0,  4'd0, 0, 1);
        vecs[6]  = mk(0, 0, 1, 0, 1, 4'd0,  4'd0, 0, 1); // down saturate
        vecs[7]  = mk(0, 0, 1, 0, 0, 4'd0,  4'd9, 1, 0); // down wrap
        vecs[8]  = mk(0, 0, 0, 1, 0, 4'd0,  4'd9, 0, 1); // hold, tc up
        vecs[9]  = mk(0, 0, 0, 0, 0, 4'd0,  4'd9, 0, 0); // hold, tc down
        vecs[10] = mk(0, 0, 1, 1, 1, 4'd0,  4'd9, 0, 1); // up saturate
        vecs[11] = mk(0, 0, 1, 1, 0, 4'd0,  4'd0, 1, 0); // up wrap
        vecs[12] = mk(0, 0, 1, 1, 0, 4'd0,  4'd1, 0, 0); // pulse drops
        vecs[13] = mk(1, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0); // clr beats en
        vecs[14] = mk(0, 1, 1, 0, 0, 4'd9,  4'd9, 0, 0); // load beats en
        vecs[15] = mk(0, 1, 0, 1, 0, 4'd15, 4'd9, 0, 1); // clamp max d

        // Reset state and tc from the reset value
        #12;
        check("reset_q", q, 0);
        check("reset_wrap", wrap, 0);
        up = 1'b1; #1;
        check("reset_tc_up", tc, 0);
        up = 1'b0; #1;
        check("reset_tc_down", tc, 1);
        up = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].d);
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
            check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
        end

        // Up count through the wrap from reset
        @(negedge clk);
        rst = 1'b0; clr = 0; load = 0; en = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            drive(0, 0, 1, 1, 0, 4'd0);
            check($sformatf("upwrap%0d_q", i), q, i % 10);
            check($sformatf("upwrap%0d_wrap", i), wrap, (i == 10) ? 1 : 0);
            check($sformatf("upwrap%0d_tc", i), tc, ((i % 10) == 9) ? 1 : 0);
        end

        // Asynchronous reset mid-cycle with en held high through release
        drive(0, 1, 0, 1, 0, 4'd6);
        check("ar_load_q", q, 6);
        @(negedge clk);
        en = 1'b1; load = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("ar_q_async", q, 0);
        check("ar_wrap_async", wrap, 0);
        @(posedge clk); #1;
        check("ar_q_held", q, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ar_resume1", q, 1);
        @(posedge clk); #1;
        check("ar_resume2", q, 2);

        // Pending wrap pulse discarded by reset
        drive(0, 1, 0, 1, 0, 4'd9);
        drive(0, 0, 1, 1, 0, 4'd0);
        check("arw_wrap_set", wrap, 1);
        rst = 1'b0;
        #1;
        check("arw_wrap_clr", wrap, 0);
        check("arw_q", q, 0);
        @(negedge clk);
        rst = 1'b1; en = 1'b0;

        // Default-parameter instance: 8-bit wrap at 255
        @(negedge clk);
        load = 1'b1; d8 = 8'd254; en = 1'b0; up = 1'b1; sat = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        check("def_load_q", q8, 254);
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        check("def_q255", q8, 255);
        check("def_tc255", tc8, 1);
        check("def_wrap0", wrap8, 0);
        @(posedge clk); #1;
        check("def_q0", q8, 0);
        check("def_wrap1", wrap8, 1);
        @(negedge clk);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
